// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add 32x32 multiplier owning the HI/LO registers.
// busy covers RUN and FIX; done pulses on the first IDLE cycle with a new product.
module mult_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNTW-1:0]      r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_neg;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_prod;

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_cnt == CNTW'(WIDTH - 1));

    // Magnitude of the most negative value wraps to 2^(WIDTH-1) as unsigned.
    assign w_abs_a  = (is_signed && srca[WIDTH-1]) ? (~srca + 1'b1) : srca;
    assign w_abs_b  = (is_signed && srcb[WIDTH-1]) ? (~srcb + 1'b1) : srcb;
    assign w_addend = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
    assign w_prod   = r_neg ? (~r_acc + 1'b1) : r_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (start) w_next = RUN;
            RUN:  if (w_last) w_next = FIX;
            FIX:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= w_abs_a;
            r_mplier <= w_abs_b;
            r_neg    <= is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
        end else if (r_state == RUN) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + w_addend;
            end
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // HI/LO change only on reset, the FIX edge, or an idle move-to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == FIX);
            if (r_state == FIX) begin
                r_hi <= w_prod[2*WIDTH-1:WIDTH];
                r_lo <= w_prod[WIDTH-1:0];
            end else if (r_state == IDLE && !start) begin
                if (mthi) r_hi <= wdata;
                if (mtlo) r_lo <= wdata;
            end
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_unit.sv
// Directed self-checking bench for mult_unit.
// Inputs driven and outputs sampled on the falling edge.
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        is_signed;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .is_signed (is_signed),
        .srca      (srca),
        .srcb      (srcb),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        start = 0; mthi = 0; mtlo = 0;
    endtask

    // Issue one multiply in cycle T and follow it to its done cycle.
    task automatic mul(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic s,
                       input logic [31:0] eh, input logic [31:0] el);
        int n;
        @(negedge clk);
        chk({tag, ".busyT"}, busy, 0);
        start = 1; is_signed = s; srca = a; srcb = b;
        @(negedge clk);
        idle_in();
        srca = 32'h5555_AAAA; srcb = 32'hFFFF_0000; is_signed = ~s;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".busylen"}, n, 33);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".hi"}, hi, eh);
        chk({tag, ".lo"}, lo, el);
        @(negedge clk);
        chk({tag, ".done1"}, done, 0);
    endtask

    initial begin
        reset_n = 0; idle_in(); is_signed = 0;
        srca = 0; srcb = 0; wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.hi", hi, 0);
        chk("rst.lo", lo, 0);
        reset_n = 1;

        mul("u7x6", 32'd7, 32'd6, 0, 32'h0, 32'h2A);
        mul("sm3x5", 32'hFFFF_FFFD, 32'd5, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        mul("um3x5", 32'hFFFF_FFFD, 32'd5, 0, 32'h4, 32'hFFFF_FFF1);
        mul("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,
            32'hFFFF_FFFE, 32'h1);
        mul("sminmin", 32'h8000_0000, 32'h8000_0000, 1,
            32'h4000_0000, 32'h0);
        mul("smin1", 32'h8000_0000, 32'h1, 1, 32'hFFFF_FFFF, 32'h8000_0000);

        // Back-to-back with ignored start and mthi while busy.
        for (int k = 0; k <= 68; k++) begin
            @(negedge clk);
            idle_in();
            if (k == 0) begin
                chk("b2b.busyT", busy, 0);
                start = 1; is_signed = 0; srca = 2; srcb = 3;
            end
            if (k == 1) chk("b2b.busy1", busy, 1);
            if (k == 10) begin
                start = 1; srca = 9; srcb = 9;
            end
            if (k == 12) begin
                mthi = 1; wdata = 32'h1234_5678;
            end
            if (k == 34) begin
                chk("b2b.done1", done, 1);
                chk("b2b.hi1", hi, 0);
                chk("b2b.lo1", lo, 6);
                start = 1; srca = 4; srcb = 4;
            end
            if (k == 35) chk("b2b.busy2", busy, 1);
            if (k == 67) chk("b2b.busy67", busy, 1);
            if (k == 68) begin
                chk("b2b.busy68", busy, 0);
                chk("b2b.done2", done, 1);
                chk("b2b.lo2", lo, 16);
            end
        end

        // Idle move-to both registers.
        @(negedge clk);
        mthi = 1; mtlo = 1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        idle_in();
        chk("mt.hi", hi, 32'hDEAD_BEEF);
        chk("mt.lo", lo, 32'hDEAD_BEEF);
        chk("mt.busy", busy, 0);

        // start beats mthi/mtlo in the same cycle.
        start = 1; mthi = 1; mtlo = 1; wdata = 32'h1111_1111;
        is_signed = 0; srca = 3; srcb = 3;
        @(negedge clk);
        idle_in();
        chk("mtst.hi", hi, 32'hDEAD_BEEF);
        chk("mtst.lo", lo, 32'hDEAD_BEEF);
        chk("mtst.busy", busy, 1);
        repeat (33) @(negedge clk);
        chk("mtst.done", done, 1);
        chk("mtst.prod", {hi, lo}, 64'd9);

        // Asynchronous reset mid-run.
        @(negedge clk);
        start = 1; srca = 7; srcb = 6;
        @(negedge clk);
        idle_in();
        repeat (14) @(negedge clk);
        chk("ar.busypre", busy, 1);
        #2 reset_n = 0;
        #1;
        chk("ar.busy", busy, 0);
        chk("ar.done", done, 0);
        chk("ar.hi", hi, 0);
        chk("ar.lo", lo, 0);
        @(negedge clk);
        reset_n = 1;
        mul("ar7x6", 32'd7, 32'd6, 0, 32'h0, 32'h2A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
